// File: rtl/fadd_pipe_if.sv
// Valid/ready bundle for the pipelined floating-point adder: an issue side
// carrying operands and a tag, and a writeback side carrying the result and flags.
interface fadd_pipe_if #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int TAGW = 5
);
    localparam int W = 1 + EW + MW;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x1;
    logic [W-1:0]    x2;
    logic            sub;
    logic [TAGW-1:0] tag_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    y;
    logic [TAGW-1:0] tag_out;
    logic            flag_nv;
    logic            flag_of;
    logic            flag_nx;

    modport master (
        output in_valid, x1, x2, sub, tag_in, out_ready,
        input  in_ready, out_valid, y, tag_out, flag_nv, flag_of, flag_nx
    );

    modport slave (
        input  in_valid, x1, x2, sub, tag_in, out_ready,
        output in_ready, out_valid, y, tag_out, flag_nv, flag_of, flag_nx
    );
endinterface

// File: rtl/fadd_pipe.sv
// Three-stage elastic floating-point add/subtract with round-to-nearest-even,
// flush-to-zero for subnormals, and per-stage stall without a skid buffer.
module fadd_pipe #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int TAGW = 5
) (
    input  logic       clk,
    input  logic       rst,
    fadd_pipe_if.slave bus
);
    localparam int W     = 1 + EW + MW;
    localparam int XW    = MW + 4;
    localparam int SHMAX = MW + 4;
    localparam int SHW   = $clog2(SHMAX + 1);
    localparam int LZW   = $clog2(XW + 1);
    localparam int WW    = 2 * MW + 7;
    localparam int EMAX  = (1 << EW) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic v1, v2, v3, r1, r2, r3;

    assign r3            = !v3 || bus.out_ready;
    assign r2            = !v2 || r3;
    assign r1            = !v1 || r2;
    assign bus.in_ready  = r1 && !rst;
    assign bus.out_valid = v3 && !rst;

    logic            sa, sb, za, zb, ia, ib, na, nb, a_ge;
    logic [EW-1:0]   ea, eb;
    logic [MW-1:0]   ma, mb, ma_f, mb_f;

    assign sa   = bus.x1[W-1];
    assign sb   = bus.x2[W-1] ^ bus.sub;
    assign ea   = bus.x1[W-2 -: EW];
    assign eb   = bus.x2[W-2 -: EW];
    assign ma   = bus.x1[MW-1:0];
    assign mb   = bus.x2[MW-1:0];
    assign za   = (ea == '0);
    assign zb   = (eb == '0);
    assign ia   = (ea == '1) && (ma == '0);
    assign ib   = (eb == '1) && (mb == '0);
    assign na   = (ea == '1) && (ma != '0);
    assign nb   = (eb == '1) && (mb != '0);
    assign ma_f = za ? '0 : ma;
    assign mb_f = zb ? '0 : mb;
    assign a_ge = {ea, ma_f} >= {eb, mb_f};

    logic [31:0]    ediff;
    logic [EW-1:0]  e_big, e_sml;
    logic [MW:0]    m_big, m_sml;
    logic [SHW-1:0] sh;
    logic           spec, spec_nv;
    logic [W-1:0]   spec_y;

    always_comb begin
        e_big   = a_ge ? ea : eb;
        e_sml   = a_ge ? eb : ea;
        m_big   = a_ge ? {!za, ma_f} : {!zb, mb_f};
        m_sml   = a_ge ? {!zb, mb_f} : {!za, ma_f};
        ediff   = 32'(e_big) - 32'(e_sml);
        sh      = (ediff > 32'(SHMAX)) ? SHW'(SHMAX) : SHW'(ediff);
        spec    = 1'b1;
        spec_nv = 1'b0;
        spec_y  = '0;
        if (na || nb || (ia && ib && (sa != sb))) begin
            spec_y  = QNAN;
            spec_nv = ia && ib;
        end else if (ia) begin
            spec_y = {sa, {EW{1'b1}}, {MW{1'b0}}};
        end else if (ib) begin
            spec_y = {sb, {EW{1'b1}}, {MW{1'b0}}};
        end else if (za && zb) begin
            // Only (-0) + (-0) keeps the negative sign.
            spec_y = {sa && sb, {(W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    logic            s1_sign, s1_esub, s1_spec, s1_nv;
    logic [EW-1:0]   s1_exp;
    logic [MW:0]     s1_mbig, s1_msml;
    logic [SHW-1:0]  s1_sh;
    logic [W-1:0]    s1_spec_y;
    logic [TAGW-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (r1 && bus.in_valid) begin
            s1_sign   <= a_ge ? sa : sb;
            s1_esub   <= sa ^ sb;
            s1_exp    <= e_big;
            s1_mbig   <= m_big;
            s1_msml   <= m_sml;
            s1_sh     <= sh;
            s1_spec   <= spec;
            s1_spec_y <= spec_y;
            s1_nv     <= spec_nv;
            s1_tag    <= bus.tag_in;
        end
    end

    logic [WW-1:0]  shifted;
    logic [XW-1:0]  x_big, x_sml, mx;
    logic [XW:0]    sum;
    logic [EW:0]    ex;
    logic [LZW-1:0] lz;

    always_comb begin
        shifted = {s1_msml, {(WW-MW-1){1'b0}}} >> s1_sh;
        x_sml   = {shifted[WW-1 -: MW+3], |shifted[MW+3:0]};
        x_big   = {s1_mbig, 3'b000};
        sum     = s1_esub ? ({1'b0, x_big} - {1'b0, x_sml})
                          : ({1'b0, x_big} + {1'b0, x_sml});
        if (sum[XW]) begin
            mx = {sum[XW:2], |sum[1:0]};
            ex = {1'b0, s1_exp} + (EW+1)'(1);
        end else begin
            mx = sum[XW-1:0];
            ex = {1'b0, s1_exp};
        end
        lz = LZW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (mx[i]) lz = LZW'(XW - 1 - i);
        end
    end

    logic            s2_sign, s2_spec, s2_nv;
    logic [EW:0]     s2_exp;
    logic [XW-1:0]   s2_mant;
    logic [LZW-1:0]  s2_lz;
    logic [W-1:0]    s2_spec_y;
    logic [TAGW-1:0] s2_tag;

    always_ff @(posedge clk) begin
        if (r2 && v1) begin
            s2_sign   <= s1_sign;
            s2_exp    <= ex;
            s2_mant   <= mx;
            s2_lz     <= lz;
            s2_spec   <= s1_spec;
            s2_spec_y <= s1_spec_y;
            s2_nv     <= s1_nv;
            s2_tag    <= s1_tag;
        end
    end

    logic [XW-1:0]      mn;
    logic signed [31:0] en, ef;
    logic               g, rr, st, rup, rc, nv_n, of_n, nx_n;
    logic [MW-1:0]      frac;
    logic [W-1:0]       y_n;

    always_comb begin
        mn          = s2_mant << s2_lz;
        en          = $signed(32'(s2_exp) - 32'(s2_lz));
        g           = mn[2];
        rr          = mn[1];
        st          = mn[0];
        rup         = g && (rr || st || mn[3]);
        {rc, frac}  = {1'b0, mn[XW-2:3]} + (MW+1)'(rup);
        ef          = en + $signed(32'(rc));
        y_n         = '0;
        nv_n        = 1'b0;
        of_n        = 1'b0;
        nx_n        = 1'b0;
        if (s2_spec) begin
            y_n  = s2_spec_y;
            nv_n = s2_nv;
        end else if (mn[XW-1]) begin
            // A zero sum (exact cancellation) falls through as +0.
            if (en <= 0) begin
                y_n  = {s2_sign, {(W-1){1'b0}}};
                nx_n = 1'b1;
            end else if (ef >= EMAX) begin
                y_n  = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
                of_n = 1'b1;
                nx_n = 1'b1;
            end else begin
                y_n  = {s2_sign, ef[EW-1:0], frac};
                nx_n = g || rr || st;
            end
        end
    end

    logic [W-1:0]    y_q;
    logic [TAGW-1:0] tag_q;
    logic            nv_q, of_q, nx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            y_q   <= '0;
            tag_q <= '0;
            nv_q  <= 1'b0;
            of_q  <= 1'b0;
            nx_q  <= 1'b0;
        end else begin
            if (r1) v1 <= bus.in_valid;
            if (r2) v2 <= v1;
            if (r3) begin
                v3 <= v2;
                if (v2) begin
                    y_q   <= y_n;
                    tag_q <= s2_tag;
                    nv_q  <= nv_n;
                    of_q  <= of_n;
                    nx_q  <= nx_n;
                end
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.tag_out = tag_q;
    assign bus.flag_nv = nv_q;
    assign bus.flag_of = of_q;
    assign bus.flag_nx = nx_q;
endmodule

// File: tb/tb_fadd_pipe.sv
// Scoreboard bench for fadd_pipe: expected results are queued at input transfer
// and compared in order at output transfer; stall, latency and reset are checked too.
module tb_fadd_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fadd_pipe_if #(.EW(8), .MW(23), .TAGW(5)) bus ();
    fadd_pipe #(.EW(8), .MW(23), .TAGW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] y; logic [4:0] tag; logic [2:0] fl; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic s; logic [31:0] y; logic [2:0] f; } vec_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    vec_t       vt[19];
    int         total = 0;
    int         bad   = 0;
    logic [4:0] tag_n = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Caller is always just after a rising edge; returns just after the transfer edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ey, input logic [2:0] ef, input bit push);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.x1       = a;
        bus.x2       = b;
        bus.sub      = s;
        bus.tag_in   = tag_n;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            step;
        end
        if (!ok) chk("in_ready_timeout", 64'(ok), 64'd1);
        if (ok && push) sb_q.push_back('{y: ey, tag: tag_n, fl: ef});
        step;
        bus.in_valid = 1'b0;
        tag_n++;
    endtask

    task automatic lat_check(input string nm);
        int n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n = i;
                break;
            end
        end
        chk(nm, 64'(n), 64'd3);
        step;
    endtask

    task automatic drain;
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) step;
        chk("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 64'(bus.out_valid), 64'd0);
            end else if (bus.out_ready) begin
                mon_e = sb_q.pop_front();
                chk("y", 64'(bus.y), 64'(mon_e.y));
                chk("tag", 64'(bus.tag_out), 64'(mon_e.tag));
                chk("flags", 64'({bus.flag_nv, bus.flag_of, bus.flag_nx}), 64'(mon_e.fl));
            end else begin
                chk("stall_y", 64'(bus.y), 64'(sb_q[0].y));
                chk("stall_tag", 64'(bus.tag_out), 64'(sb_q[0].tag));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vt = '{
            '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},
            '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},
            '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001},
            '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001},
            '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011},
            '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100},
            '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000},
            '{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b000},
            '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000},
            '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 3'b000},
            '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000},
            '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001},
            '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000},
            '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000},
            '{32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 3'b000},
            '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000},
            '{32'h00800000, 32'h00800000, 1'b0, 32'h01000000, 3'b000},
            '{32'h3F800000, 32'h80000000, 1'b1, 32'h3F800000, 3'b000}
        };
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x1        = '0;
        bus.x2        = '0;
        bus.sub       = 1'b0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        step;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_y", 64'(bus.y), 64'd0);
        chk("rst_tag", 64'(bus.tag_out), 64'd0);
        chk("rst_flags", 64'({bus.flag_nv, bus.flag_of, bus.flag_nx}), 64'd0);
        step;

        tag_n = 5'd3;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
        lat_check("latency_first");
        drain;

        foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].s, vt[i].y, vt[i].f, 1'b1);
        drain;

        // Fill the pipe against a stalled consumer, then release it.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b1);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b1);
        send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 1'b1);
        @(negedge clk);
        chk("in_ready_full", 64'(bus.in_ready), 64'd0);
        chk("out_valid_full", 64'(bus.out_valid), 64'd1);
        step;
        fork
            begin
                send(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 3'b000, 1'b1);
                send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 1'b1);
            end
            begin
                repeat (3) step;
                bus.out_ready = 1'b1;
            end
        join
        drain;

        // Reset with two operations in flight: neither may come out.
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        step;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_y", 64'(bus.y), 64'd0);
        step;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
            step;
        end
        chk("postrst_no_out", 64'(cnt), 64'd0);
        send(32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 3'b000, 1'b1);
        lat_check("latency_after_rst");
        drain;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Parametrised, elastic successor to the fixed 3-stage single-precision adder.
- Adds or subtracts two IEEE-754-style operands of configurable exponent and mantissa width, with round-to-nearest-even.
- Handles infinities and NaN, and reports exception flags.
- Uses a valid/ready handshake at both ends, with per-stage stall and bubble collapse, so it can sit directly between an issue queue and a writeback arbiter in the FPU.

Parameters:
EW, 8, exponent field width (min 4)
MW, 23, stored mantissa field width (min 4); operand width W = 1+EW+MW
TAGW, 5, width of opaque tag carried alongside each operation (e.g. destination register)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept the operation this cycle
x1  in  W  operand A {sign, exp, mant}
x2  in  W  operand B
sub  in  1  1: compute x1 - x2 (invert x2 sign); 0: x1 + x2
tag_in  in  TAGW  carried unchanged to tag_out
out_valid  out  1  result available
out_ready  in  1  consumer accepts result this cycle
y  out  W  result
tag_out  out  TAGW  tag of the result
flag_nv  out  1  invalid operation (NaN produced)
flag_of  out  1  overflow to infinity
flag_nx  out  1  inexact (rounding or flush discarded nonzero bits)

Behaviour:
- Reset: all stage valid bits clear. While rst is high, out_valid=0 and in_ready=0. y, tag_out and flags read 0 in the cycle after reset.
- Reset mid-operation discards every in-flight operation; no result is emitted for them.
- Handshake:
  - Transfer in: in_valid && in_ready on a rising edge.
  - Transfer out: out_valid && out_ready.
  - in_ready = !v1 || r2, where stage k is ready when r_k = !v_k || r_{k+1}, and r_4 = out_ready. Ready is combinational from out_ready (no skid buffer).
  - A stalled stage holds all of its registers unchanged.
  - out_valid, y, tag_out and flags stay stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 op/cycle. Results leave in issue order.
- Stage 1 (align prep):
  - Unpack both operands and apply sub.
  - Subnormal inputs (exp=0) are treated as signed zero (flush-to-zero).
  - Classify each operand as zero/normal/inf/NaN.
  - Compute the exponent difference and select the larger-magnitude operand. Ties on exponent are broken by mantissa.
  - Clamp the shift to MW+4.
- Stage 2 (add/normalise):
  - Shift the smaller mantissa right with guard, round and sticky bits; sticky = OR of all shifted-out bits.
  - Add if effective signs are equal, else subtract.
  - Handle carry-out as a right shift by 1, folding the lost bit into sticky.
  - Leading-zero count over the sum.
- Stage 3 (round/pack):
  - Left-normalise. If the exponent would be <=0, flush the result to signed zero and set flag_nx if the value was nonzero.
  - Round-nearest-even on guard/round/sticky; flag_nx = G|R|S.
  - A rounding carry increments the exponent.
  - Exponent reaching all-ones gives infinity with flag_of=1 and flag_nx=1.
- Specials (override the arithmetic path, flags otherwise 0):
  - Any NaN input gives canonical quiet NaN (sign 0, exp all-ones, mant MSB 1, rest 0), flag_nv=0 unless both operands are infinities of opposite effective sign.
  - inf + (-inf) gives canonical NaN with flag_nv=1.
  - inf with a finite operand gives that inf.
  - inf + inf of the same sign gives that inf.
- Zero sign:
  - Exact cancellation x + (-x) gives +0.
  - (-0) + (-0) gives -0.
  - (+0) + (-0) gives +0.
  - zero + finite gives the finite operand unchanged.
- Flags are valid only with out_valid and belong to that result.

Test Plan:
- Default params, out_ready=1: x1=0x3F800000, x2=0x40000000, sub=0, tag=3 at cycle 0 -> out_valid at cycle 3, y=0x40400000, tag_out=3, flags 000.
- x1=0x3F800000, x2=0x3F800000, sub=1 -> y=0x00000000. x1=0x80000000, x2=0x80000000, sub=0 -> y=0x80000000.
- Ties-to-even: 0x3F800000+0x33800000 -> 0x3F800000, nx=1. 0x3F800001+0x33800000 -> 0x3F800002, nx=1.
- Specials:
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, of=1, nx=1.
  - 0x7F800000 with sub=1 on 0x7F800000 -> 0x7FC00000, nv=1.
  - 0x7FC00001+0x3F800000 -> 0x7FC00000, nv=0.
  - Subnormal 0x00000001+0x00000001 -> 0x00000000.
- Backpressure:
  - Issue 5 back-to-back ops with out_ready=0 -> in_ready drops after the 3rd transfer.
  - Hold 4 cycles, then raise out_ready -> all 5 results emerge in order with correct tags, y stable while stalled.
- Reset: assert rst for 1 cycle with 2 ops in flight -> no out_valid afterwards for them. A new op issued after reset returns normally at +3 cycles.
